// File: rtl/press_classifier.sv
// Button sequencer: synchronise, debounce, drive the long-press counter and classify presses.
// Optional double-press detection is compiled in with `PRESS_CLASSIFIER_DOUBLE_PRESS_EN.
module press_classifier #(
  parameter int unsigned CLK_PERIOD_ns      = 20,
  parameter int unsigned DEBOUNCE_PERIOD_ns = 10_000_000,
  parameter int unsigned GAP_PERIOD_ns      = 250_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic button_in,
  input  logic timer_done,
  output logic timer_enable,
  output logic timer_clear,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic double_press
);

  localparam int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PERIOD_ns / CLK_PERIOD_ns;
  localparam int unsigned DB_W            = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    , GAP,
    SECOND
`endif
  } state_t;

  state_t            state, state_n;
  logic              sync1, sync2;
  logic [DB_W-1:0]   db_cnt;
  logic              rise_evt, fall_evt;
  logic              short_n, long_n, double_n;
  logic              enable_n, clear_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button_in;
      sync2 <= sync1;
    end
  end

  // Toggle fires on the last count so the change lands 2 + DEBOUNCE_CYCLES after the pin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      db_cnt   <= '0;
      pressed  <= 1'b0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
      if (sync2 == pressed) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt   <= '0;
        pressed  <= ~pressed;
        rise_evt <= ~pressed;
        fall_evt <= pressed;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
  localparam int unsigned GAP_CYCLES = GAP_PERIOD_ns / CLK_PERIOD_ns;
  localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);

  logic [GAP_W-1:0] gap_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap_cnt <= '0;
    end else if (state == PRESSED && state_n == GAP) begin
      gap_cnt <= GAP_W'(GAP_CYCLES);
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end
`endif

  // State register also holds the registered outputs decoded from next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      timer_enable <= 1'b0;
      timer_clear  <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      state        <= state_n;
      timer_enable <= enable_n;
      timer_clear  <= clear_n;
      short_press  <= short_n;
      long_press   <= long_n;
      double_press <= double_n;
    end
  end

  always_comb begin
    state_n  = state;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
    case (state)
      IDLE: if (rise_evt) state_n = PRESSED;
      PRESSED: begin
        if (timer_done) begin
          long_n  = 1'b1;
          state_n = LONG_HELD;
        end else if (fall_evt) begin
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
          state_n = GAP;
`else
          short_n = 1'b1;
          state_n = IDLE;
`endif
        end
      end
      // Level test, so a fall consumed by a simultaneous done still releases us.
      LONG_HELD: if (!pressed) state_n = IDLE;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
      GAP: begin
        if (rise_evt) begin
          state_n = SECOND;
        end else if (gap_cnt <= GAP_W'(1)) begin
          short_n = 1'b1;
          state_n = IDLE;
        end
      end
      SECOND: begin
        if (timer_done) begin
          long_n  = 1'b1;
          state_n = LONG_HELD;
        end else if (fall_evt) begin
          double_n = 1'b1;
          state_n  = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    enable_n = (state_n == PRESSED);
    clear_n  = (state_n == IDLE) || (state_n == LONG_HELD);
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    enable_n = enable_n || (state_n == SECOND);
    clear_n  = clear_n || (state_n == GAP);
`endif
  end

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier with a behavioural long-press counter (50 cycles).
module tb_press_classifier;

  localparam int D = 5;
  localparam int N = 50;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
  localparam int G = 100;
`else
  localparam int G = 0;
`endif
  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DOUBLE = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic button_in;
  logic timer_done;
  logic timer_enable, timer_clear, pressed;
  logic short_press, long_press, double_press;
  logic force_done;

  int   cyc = 0;
  int   tcnt = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  press_classifier #(
    .CLK_PERIOD_ns(20),
    .DEBOUNCE_PERIOD_ns(100),
    .GAP_PERIOD_ns(2000)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .button_in(button_in),
    .timer_done(timer_done),
    .timer_enable(timer_enable),
    .timer_clear(timer_clear),
    .pressed(pressed),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (timer_clear) tcnt <= 0;
    else if (timer_enable && tcnt < N) tcnt <= tcnt + 1;
  end

  assign timer_done = (tcnt == N) || force_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   n;
    int   kind;
    if (resetn) begin
      n = int'(short_press) + int'(long_press) + int'(double_press);
      if (n > 0) begin
        kind = short_press ? K_SHORT : (long_press ? K_LONG : K_DOUBLE);
        checks++;
        if (n > 1) begin
          failures++;
          $display("FAIL pulse_onehot: %0d pulses at cycle %0d, expected at most 1", n, cyc);
        end else if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != kind || e.cyc != cyc) begin
            failures++;
            $display("FAIL pulse: kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     kind, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  // Press for 'hold' cycles; if kind != 0 expect that pulse 'delay' cycles after press start.
  task automatic press(input int hold, input int kind, input int delay);
    exp_t e;
    if (kind != 0) begin
      e.kind = kind;
      e.cyc  = cyc + delay;
      sb.push_back(e);
    end
    button_in = 1'b1;
    repeat (hold) @(negedge clk);
    button_in = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pressed"}, int'(pressed), 0);
    chk({tag, "_enable"}, int'(timer_enable), 0);
    chk({tag, "_clear"}, int'(timer_clear), 1);
    chk({tag, "_pulses"}, int'({short_press, long_press, double_press}), 0);
  endtask

  initial begin
    int   p;
    int   bad;
    exp_t e;
    resetn     = 1'b0;
    button_in  = 1'b0;
    force_done = 1'b0;
    settle(3);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    settle(5);

    // Short press with per-cycle level checks on pressed / enable / clear.
    p      = cyc;
    e.kind = K_SHORT;
    e.cyc  = p + 20 + D + 3 + G;
    sb.push_back(e);
    button_in = 1'b1;
    for (int k = 1; k <= 20 + D + 8; k++) begin
      @(negedge clk);
      chk("short_pressed_lvl", int'(pressed), int'(k >= D + 2 && k < 20 + D + 2));
      chk("short_enable_lvl", int'(timer_enable), int'(k >= D + 3 && k < 20 + D + 3));
      chk("short_clear_lvl", int'(timer_clear), int'(!(k >= D + 3 && k < 20 + D + 3)));
      if (k == 20) button_in = 1'b0;
    end
    settle(150);

    // Long press: pulse N+1 cycles after enable rises (enable at p+D+3).
    press(100, K_LONG, D + 3 + N + 1);
    settle(150);
    chk("long_clear_after", int'(timer_clear), 1);

    // Glitch rejection.
    bad = 0;
    button_in = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 2) button_in = 1'b0;
      if (pressed || timer_enable) bad = 1;
    end
    chk("glitch_no_change", bad, 0);

    // timer_done coincident with the fall: long only, then back to idle.
    press(20, K_LONG, 20 + D + 3);
    settle(D + 2);
    force_done = 1'b1;
    settle(1);
    force_done = 1'b0;
    settle(150);
    chk("simul_clear_after", int'(timer_clear), 1);
    press(20, K_SHORT, 20 + D + 3 + G);
    settle(150);

`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    press(20, 0, 0);
    settle(10);
    press(20, K_DOUBLE, 20 + D + 3);
    settle(150);
    press(20, K_SHORT, 20 + D + 3 + G);
    settle(150);
    press(20, K_SHORT, 20 + D + 3 + G);
    settle(150);
`endif

    // Reset in the middle of a held press: no pulse, outputs at reset values.
    button_in = 1'b1;
    settle(30);
    chk("mid_pressed_before", int'(pressed), 1);
    resetn    = 1'b0;
    button_in = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    settle(2);
    chk_reset_outputs("rst_held");
    resetn = 1'b1;
    settle(100);
    chk_reset_outputs("rst_after");

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
